mant_sub_norm24: RTL and testbench
==================================

// Module: mant_sub_norm24
// PURPOSE
//  Sequential mantissa subtract-and-normalise stage for the FP datapath; the
//  effective-subtraction counterpart to the 24-bit CLA add path. Takes two
//  aligned 24-bit mantissas sharing one exponent and forms |a-b| with a sign.
//  Normalises left one bit per cycle, decrementing the exponent.
//  Sits between the alignment shifter and the rounder, with valid/ready on both sides.
// PARAMETERS
//  W   24  mantissa width incl. hidden bit
//  EW  8   exponent width
// PORTS
//  clk         in   1   single clock, all state on rising edge
//  rst_n       in   1   synchronous active-low reset, sampled on clk rising edge
//  in_valid    in   1   operand strobe
//  in_ready    out  1   block can accept operands
//  in_a        in   W   minuend mantissa (aligned)
//  in_b        in   W   subtrahend mantissa (aligned)
//  in_exp      in   EW  common exponent
//  out_valid   out  1   result valid, held until taken
//  out_ready   in   1   downstream accepts result
//  out_mant    out  W   normalised |a-b|
//  out_exp     out  EW  adjusted exponent
//  out_sign    out  1   1 when in_b > in_a
//  out_zero    out  1   a == b
//  out_denorm  out  1   exponent hit 0 before MSB set
//  out_shift   out  5   number of left shifts applied
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE, in_ready=1, out_valid=0,
//  all data outputs 0. Reset mid-operation aborts; no result is emitted.
//  FSM states:
//   IDLE: in_ready=1; on in_valid, latch a, b, exp and go to SUB.
//   SUB: compute d = a + ~b + 1 in W+1 bits.
//    If there is no carry-out: sign=1 and mant = b - a; else sign=0 and mant = d[W-1:0].
//    If mant==0: zero=1, exp=0, shift=0 -> DONE; else -> NORM.
//   NORM: if mant[W-1]==1 or exp==0 -> DONE.
//    Else mant <<= 1, exp -= 1, shift += 1 (one shift/cycle).
//   DONE: out_valid=1, outputs are registers and stay stable.
//    denorm = ~mant[W-1] & ~zero.
//    On out_valid & out_ready -> IDLE (in_ready=1 next cycle).
//  Handshake: in_ready asserted only in IDLE, so there is no overlap.
//   out_valid never drops without out_ready.
//   Inputs are ignored outside IDLE.
//  Latency (accept edge to out_valid): zero result 2 cycles; otherwise 3+k,
//   where k = min(leading zeros of |a-b|, in_exp). Max 3+23 = 26.
//  Exponent never wraps: it decrements only while nonzero.
//   in_exp=0 with unnormalised mant -> no shift, denorm=1.
//  out_shift saturates at 23 by construction (nonzero mant has at most 23 leading zeros).
// STRUCTURE
//  Shared fp package: W, EW, FSM state encoding (IDLE/SUB/NORM/DONE, 2 bits).
//  One sub-module: cla_sub24, a combinational lookahead subtractor (a, ~b, cin=1)
//   returning diff[W-1:0] and cout. Instantiated twice: a-b and b-a;
//   the result is selected by cout. The FSM, shifter and exponent counter
//   live in the top module.
// TESTING
//  a=800000 b=400000 exp=80 -> mant=800000 exp=7F sign=0 shift=1, valid at +4
//  a=400000 b=800000 exp=80 -> mant=800000 exp=7F sign=1 shift=1, valid at +4
//  a=b=ABCDEF exp=40 -> zero=1 mant=0 exp=0 sign=0, valid at +2
//  a=800001 b=800000 exp=80 -> mant=800000 exp=69 shift=23, valid at +26
//  a=800001 b=800000 exp=05 -> mant=000020 exp=00 denorm=1 shift=5, valid at +8
//  Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
//   Then rst_n=0 during NORM -> next cycle out_valid=0, in_ready=1, outputs 0.

Source files
------------

// File: rtl/mant_sub_norm24_pkg.sv
// mant_sub_norm24_pkg: shared widths and FSM encoding for the mantissa subtract/normalise stage
package mant_sub_norm24_pkg;
    localparam int W  = 24;
    localparam int EW = 8;
    localparam int SW = 5;
    typedef enum logic [1:0] {IDLE = 2'd0, SUB = 2'd1, NORM = 2'd2, DONE = 2'd3} state_t;
endpackage

// File: rtl/mant_sub_norm24_cla_sub24.sv
// cla_sub24: combinational subtractor a + ~b + 1 built from generate/propagate terms
module cla_sub24
    import mant_sub_norm24_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         cout
);
    logic [W-1:0] g, p;
    logic         cy;
    assign g = a & ~b;
    assign p = a ^ ~b;
    always_comb begin
        cy = 1'b1;
        diff = '0;
        for (int i = 0; i < W; i++) begin
            diff[i] = p[i] ^ cy;
            cy = g[i] | (p[i] & cy);
        end
        cout = cy;
    end
endmodule

// File: rtl/mant_sub_norm24.sv
// mant_sub_norm24: forms |a-b| with sign, then normalises left one bit per cycle
//  while decrementing the shared exponent (never below zero).
module mant_sub_norm24
    import mant_sub_norm24_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [EW-1:0] in_exp,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_mant,
    output logic [EW-1:0] out_exp,
    output logic          out_sign,
    output logic          out_zero,
    output logic          out_denorm,
    output logic [SW-1:0] out_shift
);
    state_t       state, nstate;
    logic [W-1:0] ra, rb, d_ab, d_ba;
    logic         c_ab, c_ba, eq, norm_done;
    cla_sub24 u_ab (.a(ra), .b(rb), .diff(d_ab), .cout(c_ab));
    cla_sub24 u_ba (.a(rb), .b(ra), .diff(d_ba), .cout(c_ba));
    // both directions carry out only when the operands are equal
    assign eq        = c_ab & c_ba;
    assign norm_done = out_mant[W-1] | (out_exp == '0);
    assign in_ready  = (state == IDLE);
    always_comb begin
        nstate = state;
        case (state)
            IDLE:    nstate = in_valid ? SUB : IDLE;
            SUB:     nstate = eq ? DONE : NORM;
            NORM:    nstate = norm_done ? DONE : NORM;
            default: nstate = (out_valid & out_ready) ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ra         <= '0;
            rb         <= '0;
            out_valid  <= 1'b0;
            out_mant   <= '0;
            out_exp    <= '0;
            out_sign   <= 1'b0;
            out_zero   <= 1'b0;
            out_denorm <= 1'b0;
            out_shift  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ra        <= in_a;
                    rb        <= in_b;
                    out_exp   <= in_exp;
                    out_shift <= '0;
                end
                SUB: begin
                    out_mant <= c_ab ? d_ab : d_ba;
                    out_sign <= ~c_ab;
                    out_zero <= eq;
                    if (eq) out_exp <= '0;
                end
                NORM: if (!norm_done) begin
                    out_mant  <= out_mant << 1;
                    out_exp   <= out_exp - EW'(1);
                    out_shift <= out_shift + SW'(1);
                end
                default: begin
                    // valid rises one cycle after entering DONE, with denorm captured alongside
                    if (!out_valid) begin
                        out_valid  <= 1'b1;
                        out_denorm <= ~out_mant[W-1] & ~out_zero;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mant_sub_norm24.sv
// tb_mant_sub_norm24: scoreboard bench for the mantissa subtract/normalise stage
module tb_mant_sub_norm24;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [23:0] in_a, in_b, out_mant;
    logic [7:0]  in_exp, out_exp;
    logic        out_sign, out_zero, out_denorm;
    logic [4:0]  out_shift;
    int          asserts = 0, fails = 0;

    typedef struct {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        sign, zero, denorm;
        logic [4:0]  shift;
        int          lat;
    } exp_t;
    exp_t q[$];

    mant_sub_norm24 dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_exp(in_exp), .out_valid(out_valid),
        .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
        .out_sign(out_sign), .out_zero(out_zero), .out_denorm(out_denorm),
        .out_shift(out_shift)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e);
        exp_t r;
        logic [23:0] d;
        int k;
        d = (a >= b) ? a - b : b - a;
        r.sign = (b > a);
        r.zero = (d == 0);
        k = 0;
        if (d == 0) begin
            r.mant = 0; r.exp = 0; r.shift = 0; r.denorm = 0; r.lat = 2;
        end else begin
            while (k < int'(e) && !d[23]) begin
                d = d << 1;
                k++;
            end
            r.mant = d; r.exp = e - 8'(k); r.shift = 5'(k); r.denorm = ~d[23]; r.lat = 3 + k;
        end
        return r;
    endfunction

    task automatic send(input logic [23:0] a, input logic [23:0] b, input logic [7:0] e);
        @(negedge clk);
        asserts++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready: in_ready=%b required 1", in_ready);
        end
        in_a = a; in_b = b; in_exp = e; in_valid = 1'b1;
        q.push_back(model(a, b, e));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic recv(input int hold);
        exp_t x;
        int n;
        logic [23:0] m0;
        logic [7:0] e0;
        x = q.pop_front();
        n = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1 n++;
            if (out_valid) break;
        end
        asserts++;
        if (!out_valid || n != x.lat) begin
            fails++;
            $display("FAIL latency: valid=%b cycles=%0d required %0d", out_valid, n, x.lat);
        end
        asserts++;
        if (out_mant !== x.mant || out_exp !== x.exp || out_shift !== x.shift) begin
            fails++;
            $display("FAIL result: mant=%h exp=%h shift=%0d required mant=%h exp=%h shift=%0d",
                     out_mant, out_exp, out_shift, x.mant, x.exp, x.shift);
        end
        asserts++;
        if (out_sign !== x.sign || out_zero !== x.zero || out_denorm !== x.denorm) begin
            fails++;
            $display("FAIL flags: sign=%b zero=%b denorm=%b required %b %b %b",
                     out_sign, out_zero, out_denorm, x.sign, x.zero, x.denorm);
        end
        m0 = out_mant; e0 = out_exp;
        for (int h = 0; h < hold; h++) begin
            if (h == 2) begin
                in_valid = 1'b1; in_a = 24'h123456; in_b = 24'h000001; in_exp = 8'h10;
            end
            @(posedge clk);
            #1 asserts++;
            if (!out_valid || in_ready || out_mant !== m0 || out_exp !== e0) begin
                fails++;
                $display("FAIL hold: valid=%b ready=%b mant=%h exp=%h required 1 0 %h %h",
                         out_valid, in_ready, out_mant, out_exp, m0, e0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        asserts++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL handoff: valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic check_idle(input string nm);
        asserts++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mant !== 0 || out_exp !== 0 ||
            out_shift !== 0 || out_sign !== 0 || out_zero !== 0 || out_denorm !== 0) begin
            fails++;
            $display("FAIL %s: valid=%b ready=%b mant=%h exp=%h shift=%0d s=%b z=%b d=%b required idle zeros",
                     nm, out_valid, in_ready, out_mant, out_exp, out_shift, out_sign, out_zero, out_denorm);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_idle("reset");
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        send(24'h800000, 24'h400000, 8'h80); recv(0);
        send(24'h400000, 24'h800000, 8'h80); recv(0);
        send(24'hABCDEF, 24'hABCDEF, 8'h40); recv(0);
        send(24'h800001, 24'h800000, 8'h80); recv(0);
        send(24'h800001, 24'h800000, 8'h05); recv(0);
        send(24'h400000, 24'h000000, 8'h00); recv(0);
        send(24'h000000, 24'hFFFFFF, 8'h01); recv(0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [23:0] a, b;
            a = 24'($urandom);
            b = (i % 2) ? a ^ 24'($urandom >> $urandom_range(8, 31)) : 24'($urandom);
            send(a, b, 8'($urandom_range(0, (i % 3 == 0) ? 12 : 255)));
            recv(0);
        end
    endtask

    task automatic test_hold();
        send(24'h300000, 24'h100000, 8'h20);
        recv(10);
    endtask

    task automatic test_back_to_back();
        send(24'h000010, 24'h000001, 8'hFF); recv(0);
        send(24'hFFFFFF, 24'h000000, 8'h01); recv(0);
        send(24'h000001, 24'h000002, 8'h30); recv(0);
    endtask

    task automatic test_reset_mid();
        send(24'h800001, 24'h800000, 8'h80);
        void'(q.pop_back());
        repeat (5) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk);
        #1 check_idle("reset_mid");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_idle("after_reset_mid");
        send(24'h800000, 24'h400000, 8'h80); recv(0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_exp = '0;
        test_reset();
        test_vectors();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
